// File: rtl/mvau_weight_ctrl_if.sv
// mvau_weight_ctrl_if -- bundle of the job handshake, the weight-memory read
// port and the weight stream of mvau_weight_ctrl.
//   master : the controller side (drives busy/done, wmem_addr, wt_out/wt_valid)
//   slave  : the environment side (drives start, wmem_out, wt_ready)
// Signals:
//   start/busy/done      job control
//   wmem_addr/wmem_out   synchronous weight memory, data one cycle after addr
//   wt_out/wt_valid/...  valid/ready weight stream toward the MAC array
interface mvau_weight_ctrl_if #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_ADDR_BW = 4
) ();
  logic                    start;
  logic                    busy;
  logic                    done;
  logic [WMEM_ADDR_BW-1:0] wmem_addr;
  logic [SIMD*TW-1:0]      wmem_out;
  logic [SIMD*TW-1:0]      wt_out;
  logic                    wt_valid;
  logic                    wt_ready;

  modport master (
    input  start, wmem_out, wt_ready,
    output busy, done, wmem_addr, wt_out, wt_valid
  );

  modport slave (
    output start, wmem_out, wt_ready,
    input  busy, done, wmem_addr, wt_out, wt_valid
  );
endinterface

// File: rtl/mvau_weight_ctrl.sv
// mvau_weight_ctrl -- streams the weight memory NUM_REPS times per job.
// Reads are issued only when the 2-entry output FIFO is guaranteed to have a
// slot for the returning word, so the stream never overflows and still runs
// at one word per cycle while wt_ready stays high.
// Ports:
//   aclk    clock, rising edge
//   areset  synchronous active-high reset
//   bus     mvau_weight_ctrl_if.master (start/busy/done, memory port, stream)
module mvau_weight_ctrl #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4,
  parameter int NUM_REPS     = 1
) (
  input  logic                aclk,
  input  logic                areset,
  mvau_weight_ctrl_if.master  bus
);
  localparam int DW      = SIMD * TW;
  localparam int PASS_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
  localparam logic [PASS_BW-1:0]      LAST_PASS = PASS_BW'(NUM_REPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [WMEM_ADDR_BW-1:0] cnt_q;      // next address to issue
  logic [WMEM_ADDR_BW-1:0] addr_q;     // last issued address
  logic [PASS_BW-1:0]      pass_q;
  logic                    inflight_q; // read issued last cycle, data arrives now
  logic [1:0]              occ_q;
  logic [DW-1:0]           head_q, tail_q;

  logic       pop, issue, last_issue, drained;
  logic [2:0] credit;

  assign pop        = (occ_q != 2'd0) && bus.wt_ready;
  // Slots committed after this cycle: stored + returning - leaving.
  assign credit     = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue      = (state_q == RUN) && (credit < 3'd2);
  assign last_issue = issue && (cnt_q == LAST_ADDR) && (pass_q == LAST_PASS);
  assign drained    = !inflight_q && (occ_q == 2'd0);

  // Address is shown combinationally in the issue cycle; otherwise it holds.
  assign bus.wmem_addr = issue ? cnt_q : addr_q;
  assign bus.wt_out    = head_q;
  assign bus.wt_valid  = (occ_q != 2'd0);

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (drained) begin
          bus.done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;

      if (issue) begin
        addr_q <= cnt_q;
        if (cnt_q == LAST_ADDR) begin
          cnt_q  <= '0;
          // Final wrap of the job leaves the pass counter ready for the next start.
          pass_q <= last_issue ? '0 : pass_q + PASS_BW'(1);
        end else begin
          cnt_q <= cnt_q + WMEM_ADDR_BW'(1);
        end
      end

      // Returning data (inflight_q) is the push side of the FIFO.
      case ({inflight_q, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= bus.wmem_out;
          else               tail_q <= bus.wmem_out;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) head_q <= tail_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) head_q <= bus.wmem_out;
          else begin
            head_q <= tail_q;
            tail_q <= bus.wmem_out;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mvau_weight_ctrl.sv
// tb_mvau_weight_ctrl -- random and directed checks of mvau_weight_ctrl.
// DUT A: SIMD=4 TW=2 depth 4, 2 passes, memory A0..A3.
// DUT B: depth 1, 3 passes, memory 5C.
// A queue of expected words (address order, passes repeated) is consumed on
// every accepted beat of DUT A.
module tb_mvau_weight_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mvau_weight_ctrl_if #(.SIMD(4), .TW(2), .WMEM_ADDR_BW(4)) ba ();
  mvau_weight_ctrl_if #(.SIMD(4), .TW(2), .WMEM_ADDR_BW(4)) bb ();

  mvau_weight_ctrl #(.SIMD(4), .TW(2), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4), .NUM_REPS(2))
    u_a (.aclk(clk), .areset(rst), .bus(ba.master));
  mvau_weight_ctrl #(.SIMD(4), .TW(2), .WMEM_DEPTH(1), .WMEM_ADDR_BW(4), .NUM_REPS(3))
    u_b (.aclk(clk), .areset(rst), .bus(bb.master));

  // synchronous weight memories
  always @(posedge clk) begin
    ba.wmem_out <= (ba.wmem_addr < 4'd4) ? (8'hA0 + {4'd0, ba.wmem_addr}) : 8'hEE;
    bb.wmem_out <= (bb.wmem_addr == 4'd0) ? 8'h5C : 8'hEE;
  end

  int n_chk = 0;
  int n_err = 0;
  int done_cnt;
  logic [7:0] expq[$];
  logic pv = 1'b0, pr = 1'b0, rst_prev = 1'b1;
  logic [7:0] pd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // expected stream for one job of DUT A
  task automatic push_job_a();
    for (int k = 0; k < 8; k++) expq.push_back(8'hA0 + 8'(k % 4));
  endtask

  // per-cycle scoreboard / stability check of DUT A, at the negedge
  task automatic step_a();
    if (ba.wt_valid && ba.wt_ready) begin
      if (expq.size() == 0) chk("extra_word_valid", ba.wt_valid, 0);
      else                  chk("word", ba.wt_out, expq.pop_front());
    end
    if (pv && !pr && !rst_prev) begin
      chk("hold_valid", ba.wt_valid, 1);
      chk("hold_data", ba.wt_out, pd);
    end
    if (ba.done) done_cnt++;
    pv = ba.wt_valid; pr = ba.wt_ready; pd = ba.wt_out; rst_prev = rst;
  endtask

  task automatic samp(); @(negedge clk); step_a(); endtask
  task automatic adv();  @(posedge clk); #1;       endtask

  // one full job on DUT A with wt_ready at duty% and optional stray starts
  task automatic run_a(input int duty, input bit rnd_start);
    bit fin = 0;
    int k = 0;
    push_job_a();
    done_cnt = 0;
    ba.start = 1'b1;
    ba.wt_ready = ($urandom_range(0, 99) < duty);
    samp(); adv();
    while (!fin && k < 400) begin
      ba.start = rnd_start && ($urandom_range(0, 9) == 0);
      ba.wt_ready = ($urandom_range(0, 99) < duty);
      samp();
      if (ba.done) fin = 1;
      adv();
      k++;
    end
    ba.start = 1'b0;
    chk("job_finished", fin, 1);
    samp();
    chk("busy_after_done", ba.busy, 0);
    adv();
    chk("done_per_job", done_cnt, 1);
    chk("job_words_left", expq.size(), 0);
    expq.delete();
  endtask

  initial begin
    int nb;
    rst = 1'b1;
    ba.start = 1'b0; ba.wt_ready = 1'b0;
    bb.start = 1'b0; bb.wt_ready = 1'b0;
    done_cnt = 0;
    repeat (3) adv();
    samp();
    chk("rst_busy", ba.busy, 0);
    chk("rst_done", ba.done, 0);
    chk("rst_valid", ba.wt_valid, 0);
    chk("rst_addr", ba.wmem_addr, 0);
    chk("rst_wt_out", ba.wt_out, 0);
    chk("rst_b_valid", bb.wt_valid, 0);
    adv();
    // reset wins over a simultaneous start
    ba.start = 1'b1;
    samp(); adv();
    rst = 1'b0; ba.start = 1'b0;
    samp();
    chk("rst_over_start_busy", ba.busy, 0);
    adv();

    // basic streaming, exact latency
    ba.wt_ready = 1'b1;
    push_job_a();
    done_cnt = 0;
    for (int c = 0; c < 14; c++) begin
      ba.start = (c == 0);
      samp();
      chk($sformatf("basic_valid_c%0d", c), ba.wt_valid, (c >= 3 && c <= 10));
      chk($sformatf("basic_done_c%0d", c), ba.done, (c == 11));
      chk($sformatf("basic_busy_c%0d", c), ba.busy, (c >= 1 && c <= 11));
      if (c == 1) chk("basic_addr_c1", ba.wmem_addr, 0);
      if (c == 2) chk("basic_addr_c2", ba.wmem_addr, 1);
      adv();
    end
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_words_left", expq.size(), 0);
    expq.delete();

    // backpressure in cycles 3..8
    push_job_a();
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      ba.start = (c == 0);
      ba.wt_ready = !(c >= 3 && c <= 8);
      samp();
      if (c >= 3 && c <= 8) begin
        chk("bp_valid", ba.wt_valid, 1);
        chk("bp_data", ba.wt_out, 8'hA0);
      end
      if (c == 8) chk("bp_addr_held", ba.wmem_addr, 1);
      adv();
    end
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_words_left", expq.size(), 0);
    expq.delete();

    // random backpressure with stray starts while busy
    for (int j = 0; j < 1000; j++) run_a(30, 1'b1);

    // reset in RUN after 3 words
    push_job_a();
    ba.wt_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      ba.start = (c == 0);
      samp(); adv();
    end
    chk("mid_words_taken", expq.size(), 5);
    ba.wt_ready = 1'b0;
    rst = 1'b1;
    samp(); adv();
    rst = 1'b0;
    ba.wt_ready = 1'b1;
    samp();
    chk("mid_rst_busy", ba.busy, 0);
    chk("mid_rst_valid", ba.wt_valid, 0);
    chk("mid_rst_done", ba.done, 0);
    chk("mid_rst_addr", ba.wmem_addr, 0);
    chk("mid_rst_wt_out", ba.wt_out, 0);
    expq.delete();
    adv();
    repeat (6) begin samp(); adv(); end
    run_a(100, 1'b0);

    // DUT B: depth 1, three passes
    ba.wt_ready = 1'b0;
    bb.wt_ready = 1'b1;
    nb = 0; done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      bb.start = (c == 0);
      samp();
      chk($sformatf("b_valid_c%0d", c), bb.wt_valid, (c >= 3 && c <= 5));
      chk($sformatf("b_done_c%0d", c), bb.done, (c == 6));
      if (bb.wt_valid) chk("b_data", bb.wt_out, 8'h5C);
      if (bb.wt_valid && bb.wt_ready) nb++;
      adv();
    end
    chk("b_words", nb, 3);
    nb = 0;
    bb.start = 1'b1;
    begin
      bit fin = 0;
      for (int k = 0; k < 200 && !fin; k++) begin
        samp();
        if (bb.wt_valid && bb.wt_ready) begin
          chk("b_rand_data", bb.wt_out, 8'h5C);
          nb++;
        end
        if (bb.done) fin = 1;
        adv();
        bb.start = 1'b0;
        bb.wt_ready = ($urandom_range(0, 99) < 30);
      end
      chk("b_rand_finished", fin, 1);
    end
    chk("b_rand_words", nb, 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
